// File: rtl/cdc_app_pkg.sv
// rtl/cdc_app_pkg.sv - shared mode encodings, ASCII bounds and byte transform for cdc_app_fifo
package cdc_app_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_INC      = 2'b01,
        MODE_CASE     = 2'b10,
        MODE_PASS_ALT = 2'b11
    } mode_e;

    localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;
    localparam logic [7:0] ASCII_DIGIT_8 = 8'h38;
    localparam logic [7:0] ASCII_DIGIT_9 = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    function automatic logic [7:0] byte_xform(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] r;
        r = b;
        case (mode_e'(mode))
            MODE_INC: begin
                if (b >= ASCII_DIGIT_0 && b <= ASCII_DIGIT_8) begin
                    r = b + 8'd1;
                end else if (b == ASCII_DIGIT_9) begin
                    r = ASCII_DIGIT_0;
                end
            end
            MODE_CASE: begin
                if (b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) begin
                    r = b + ASCII_CASE_DELTA;
                end else if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) begin
                    r = b - ASCII_CASE_DELTA;
                end
            end
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cdc_app_fifo_if.sv
// rtl/cdc_app_fifo_if.sv - usb_cdc OUT/IN byte stream handshakes seen by cdc_app_fifo
interface cdc_app_fifo_if;

    logic [7:0] out_data_i;
    logic       out_valid_i;
    logic       out_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;

    // usb_cdc side: sources OUT bytes, sinks IN bytes
    modport master (
        output out_data_i,
        output out_valid_i,
        input  out_ready_o,
        input  in_data_o,
        input  in_valid_o,
        output in_ready_i
    );

    modport slave (
        input  out_data_i,
        input  out_valid_i,
        output out_ready_o,
        output in_data_o,
        output in_valid_o,
        input  in_ready_i
    );

endinterface

// File: rtl/cdc_app_fifo_mem.sv
// rtl/cdc_app_fifo_mem.sv - DEPTH x 8 byte store, synchronous write, registered read (EBR friendly)
module cdc_app_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] mem [DEPTH];

    // Read returns the old contents on an address collision; the top bypasses that case.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cdc_app_fifo.sv
// rtl/cdc_app_fifo.sv - usb_cdc OUT->IN byte loop with per-byte transform, circular FIFO and flush
module cdc_app_fifo
    import cdc_app_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter bit TRANSFORM_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          mode_i,
    input  logic                flush_i,
    cdc_app_fifo_if.slave       bus,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                overrun_o
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
    logic [DEPTH_LOG2-1:0] mem_raddr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overrun_q;
    logic                  bypass_q;
    logic [7:0]            bypass_data;
    logic [7:0]            mem_rdata;
    logic [7:0]            wdata;
    logic                  out_ready;
    logic                  in_valid;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;

    assign out_ready = !rst_i && (count_q < FULL_CNT);
    assign in_valid  = (count_q != '0);
    assign wr_fire   = bus.out_valid_i && out_ready;
    assign rd_fire   = in_valid && bus.in_ready_i;
    assign mem_we    = wr_fire && !flush_i;
    assign wdata     = TRANSFORM_EN ? byte_xform(bus.out_data_i, mode_i) : bus.out_data_i;

    // The memory is addressed with next cycle's head so in_data_o is ready right after the edge.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (rd_fire) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        mem_raddr = rd_ptr_nxt;
        if (rst_i || flush_i) begin
            mem_raddr = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            bypass_q    <= 1'b0;
            bypass_data <= 8'h00;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            bypass_q  <= 1'b0;
            overrun_q <= overrun_q || (count_q != '0);
        end else begin
            if (wr_fire) begin
                wr_ptr      <= wr_ptr + 1'b1;
                bypass_data <= wdata;
            end
            rd_ptr <= rd_ptr_nxt;
            // A byte written into the slot that becomes the head is not yet readable from memory.
            bypass_q <= wr_fire && (wr_ptr == rd_ptr_nxt);
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    cdc_app_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign bus.out_ready_o = out_ready;
    assign bus.in_valid_o  = in_valid;
    assign bus.in_data_o   = in_valid ? (bypass_q ? bypass_data : mem_rdata) : 8'h00;
    assign count_o         = count_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_cdc_app_fifo.sv
// tb/tb_cdc_app_fifo.sv - directed vector bench for cdc_app_fifo
module tb_cdc_app_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [1:0]          mode_i;
    logic                flush_i;
    logic [DEPTH_LOG2:0] count_o;
    logic                overrun_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    cdc_app_fifo_if bus();

    cdc_app_fifo #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .TRANSFORM_EN(1'b1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .mode_i   (mode_i),
        .flush_i  (flush_i),
        .bus      (bus),
        .count_o  (count_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [7:0] data, input logic [1:0] mode,
                         input logic ready);
        bus.out_valid_i = valid;
        bus.out_data_i  = data;
        mode_i          = mode;
        bus.in_ready_i  = ready;
    endtask

    task automatic add_str(input logic [1:0] mode, input string din, input string exp);
        for (int i = 0; i < din.len(); i++) begin
            vecs.push_back('{mode: mode, din: din[i], exp: exp[i]});
        end
    endtask

    initial begin
        string s_in;
        string s_exp;

        rst_i   = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 1'b0);

        for (int i = 1; i <= 7; i++) begin
            vecs.push_back('{mode: 2'b00, din: 8'(i), exp: 8'(i)});
        end
        add_str(2'b01, "12345678", "23456789");
        add_str(2'b01, "9", "0");
        vecs.push_back('{mode: 2'b01, din: 8'h21, exp: 8'h21});
        add_str(2'b10, "ABCDEFGHqrstuvwx", "abcdefghQRSTUVWX");
        add_str(2'b11, "Zz9", "Zz9");

        // Reset state
        @(negedge clk);
        check("rst_out_ready", bus.out_ready_o, 0);
        @(negedge clk);
        check("rst_in_valid", bus.in_valid_o, 0);
        check("rst_in_data", bus.in_data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_overrun", overrun_o, 0);
        rst_i = 1'b0;
        #1;
        check("out_ready_after_rst", bus.out_ready_o, 1);

        // Streaming table: each byte must appear one cycle after its write
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].din, vecs[i].mode, 1'b1);
            @(negedge clk);
            check($sformatf("stream_valid[%0d]", i), bus.in_valid_o, 1);
            check($sformatf("stream_data[%0d]", i), bus.in_data_o, vecs[i].exp);
            check($sformatf("stream_count[%0d]", i), count_o, 1);
        end
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        @(negedge clk);
        check("stream_drained_count", count_o, 0);
        check("stream_drained_valid", bus.in_valid_o, 0);

        // Mode change mid-stream leaves stored bytes transformed
        s_in  = "ABCDef";
        s_exp = "abcdef";
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, s_in[i], (i < 4) ? 2'b10 : 2'b00, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("modeswitch_data[%0d]", i), bus.in_data_o, s_exp[i]);
            @(negedge clk);
        end
        check("modeswitch_empty", count_o, 0);

        // Fill to full, hold off the 17th byte, free one slot, then drain across the wrap
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 2'b00, 1'b0);
            @(negedge clk);
        end
        check("full_count", count_o, DEPTH);
        check("full_out_ready", bus.out_ready_o, 0);
        drive(1'b1, 8'hB0, 2'b00, 1'b0);
        @(negedge clk);
        check("full_held_count", count_o, DEPTH);
        check("full_head", bus.in_data_o, 8'hA0);
        drive(1'b1, 8'hB0, 2'b00, 1'b1);
        @(negedge clk);
        check("full_read_count", count_o, DEPTH - 1);
        check("full_read_out_ready", bus.out_ready_o, 1);
        drive(1'b1, 8'hB0, 2'b00, 1'b0);
        @(negedge clk);
        check("full_17th_count", count_o, DEPTH);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("wrap_valid[%0d]", i), bus.in_valid_o, 1);
            check($sformatf("wrap_data[%0d]", i), bus.in_data_o,
                  (i == DEPTH) ? 8'hB0 : 8'hA0 + 8'(i));
            @(negedge clk);
        end
        check("wrap_empty", count_o, 0);

        // Flush with 5 bytes stored and a simultaneous write
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 2'b00, 1'b0);
            @(negedge clk);
        end
        check("preflush_count", count_o, 5);
        drive(1'b1, 8'h77, 2'b00, 1'b1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_in_valid", bus.in_valid_o, 0);
        check("flush_overrun", overrun_o, 1);
        drive(1'b1, 8'h55, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00, 1'b0);
        check("postflush_valid", bus.in_valid_o, 1);
        check("postflush_data", bus.in_data_o, 8'h55);
        check("postflush_count", count_o, 1);
        check("overrun_sticky", overrun_o, 1);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        @(negedge clk);

        // Reset mid-stream with 3 bytes stored
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 2'b00, 1'b0);
            @(negedge clk);
        end
        check("prereset_count", count_o, 3);
        drive(1'b1, 8'h99, 2'b00, 1'b1);
        rst_i = 1'b1;
        #1;
        check("midrst_out_ready", bus.out_ready_o, 0);
        @(negedge clk);
        check("midrst_count", count_o, 0);
        check("midrst_in_valid", bus.in_valid_o, 0);
        check("midrst_in_data", bus.in_data_o, 0);
        check("midrst_overrun", overrun_o, 0);
        rst_i = 1'b0;
        drive(1'b1, 8'h42, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h43, 2'b00, 1'b1);
        check("resume_data0", bus.in_data_o, 8'h42);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        check("resume_data1", bus.in_data_o, 8'h43);
        check("resume_overrun", overrun_o, 0);
        @(negedge clk);
        check("resume_empty", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_app_fifo.md
Name: cdc_app_fifo

Overview:
- Application-side byte stage inside the Fomu SoC, between the usb_cdc OUT byte stream (host→device) and the usb_cdc IN byte stream (device→host).
- Accepts bytes from usb_cdc OUT, optionally transforms each byte, buffers it in a circular FIFO and returns it on usb_cdc IN.
- Applies backpressure so that usb_cdc NAKs OUT packets while the FIFO is full.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in bytes (depth = 2**DEPTH_LOG2, legal range 2..8)
- TRANSFORM_EN, 1, 1 = mode_i transforms enabled; 0 = mode_i ignored and all bytes pass through

Ports:
- clk_i  in  1  system clock, same clock as usb_cdc app interface
- rst_i  in  1  synchronous active-high reset
- mode_i  in  2  transform select: 00 pass, 01 digit increment, 10 letter case swap, 11 pass
- flush_i  in  1  single-cycle request to discard all buffered bytes
- out_data_i  in  8  byte from usb_cdc OUT stream
- out_valid_i  in  1  out_data_i valid
- out_ready_o  out  1  block accepts out_data_i this cycle
- in_data_o  out  8  byte to usb_cdc IN stream
- in_valid_o  out  1  in_data_o valid
- in_ready_i  in  1  usb_cdc accepts in_data_o this cycle
- count_o  out  DEPTH_LOG2+1  number of bytes stored
- overrun_o  out  1  sticky flag: flush discarded at least one byte

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk_i and rst_i.
- Reset values: out_ready_o=0 during reset, in_valid_o=0, in_data_o=0, count_o=0, overrun_o=0. Read and write pointers are 0.
- Write handshake:
  - out_ready_o = !rst_i && (count_o < DEPTH).
  - A write occurs when out_valid_i && out_ready_o at the clock edge.
  - The stored byte is transform(out_data_i, mode_i), evaluated in the same cycle.
- Read handshake:
  - in_valid_o = (count_o != 0). in_data_o = mem[rd_ptr] (FWFT, registered memory output or equivalent).
  - A read occurs when in_valid_o && in_ready_i. in_data_o and in_valid_o stay stable until the read occurs.
- Latency: a byte written at edge N is visible on in_data_o with in_valid_o=1 after edge N when the FIFO was empty (1 cycle). There is no fall-through in the same cycle.
- Transforms (only when TRANSFORM_EN=1):
  - 01: '0'..'8' map to +1; '9' maps to '0'. All other bytes are unchanged.
  - 10: 'A'..'Z' map to +0x20; 'a'..'z' map to −0x20. All other bytes are unchanged.
  - 00/11: identity.
  - mode_i is sampled per byte at write time. Changing mode_i never alters bytes already stored.
- Pointers: DEPTH_LOG2-bit, wrap modulo DEPTH. count_o is DEPTH_LOG2+1 bits, so full (count=DEPTH) is distinguishable from empty.
- Simultaneous read and write:
  - When not empty and not full: both occur and count is unchanged.
  - When full: the read frees a slot, but out_ready_o was 0, so only the read occurs.
  - When empty: only the write occurs, because in_valid_o=0.
- Flush:
  - At the edge where flush_i=1: pointers reset to 0, count becomes 0, and in_valid_o is 0 the next cycle.
  - Any simultaneous write or read that cycle is discarded.
  - overrun_o is set if count_o != 0 at the flush. Only rst_i clears overrun_o.
- Reset mid-transfer: all pending data is discarded. No handshake completes during the reset cycle.

Decomposition:
- Shared package cdc_app_pkg holds:
  - mode encodings MODE_PASS=2'b00, MODE_INC=2'b01, MODE_CASE=2'b10
  - ASCII bound constants
  - function byte_xform(byte, mode)
- One sub-module is natural: cdc_app_fifo_mem. It is a DEPTH×8 synchronous-write memory with a registered read port, so it maps to iCE40 EBR.

Test Plan:
- Mode 00: write 0x01..0x07 with in_ready_i=1 → in stream returns 0x01..0x07 in order; the first byte is valid 1 cycle after its write; count_o returns to 0.
- Mode 01: write "12345678", then "9" → read "23456789", then "0". Non-digit 0x21 passes as 0x21.
- Mode 10: write "ABCDEFGHqrstuvwx" → read "abcdefghQRSTUVWX". Switching mode to 00 mid-stream leaves already-stored bytes transformed.
- Fill with DEPTH=16 bytes, in_ready_i=0:
  - count_o=16 and out_ready_o=0; a 17th out_valid_i is held off.
  - Raising in_ready_i for one cycle gives count 15, then the 17th write is accepted.
  - Data order is intact across pointer wrap.
- Flush with 5 bytes stored and a write in the same cycle → count_o=0 and in_valid_o=0 next cycle, overrun_o=1. The next written byte 0x55 is read back first.
- Assert rst_i mid-stream with 3 bytes stored → all outputs take reset values. overrun_o=0 after release. Normal operation resumes with pointers at 0.
